// File: rtl/hci_l2_bank_arbiter_if.sv
// Bundle of requester-side and bank-side signals for the L2 bank arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment that drives the requesters and models the bank.
interface hci_l2_bank_arbiter_if #(
    parameter int N  = 6,
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BW = DW / 8;

    // requester side
    logic [N-1:0]    req;
    logic [N*AW-1:0] add;
    logic [N-1:0]    wen;
    logic [N*DW-1:0] data;
    logic [N*BW-1:0] be;
    logic [N-1:0]    gnt;
    logic [N-1:0]    r_valid;
    logic [DW-1:0]   r_data;

    // bank side
    logic            mem_req;
    logic [AW-1:0]   mem_add;
    logic            mem_wen;
    logic [DW-1:0]   mem_data;
    logic [BW-1:0]   mem_be;
    logic            mem_gnt;
    logic [DW-1:0]   mem_r_data;

    // status
    logic            starved;

    modport slave (
        input  req, add, wen, data, be, mem_gnt, mem_r_data,
        output gnt, r_valid, r_data, mem_req, mem_add, mem_wen, mem_data, mem_be, starved
    );

    modport master (
        output req, add, wen, data, be, mem_gnt, mem_r_data,
        input  gnt, r_valid, r_data, mem_req, mem_add, mem_wen, mem_data, mem_be, starved
    );
endinterface

// File: rtl/hci_l2_bank_arbiter.sv
// L2 bank arbiter: N_CH0 high-priority and N_CH1 low-priority requesters share
// one SRAM bank port. Fixed priority between the two classes, round-robin inside
// each class, and a stall counter that forces a low-priority win once the
// low-priority class has lost MAX_STALL cycles in a row.
// The winner is chosen only from req and the arbiter state. It never depends on
// mem_gnt, so there is no combinational path from mem_gnt back into the choice.
module hci_l2_bank_arbiter #(
    parameter int N_CH0     = 4,
    parameter int N_CH1     = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_STALL = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    hci_l2_bank_arbiter_if.slave  bus
);
    localparam int N   = N_CH0 + N_CH1;
    localparam int BW  = DW / 8;
    localparam int CW  = $clog2(MAX_STALL + 1);
    localparam int P0W = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
    localparam int P1W = (N_CH1 > 1) ? $clog2(N_CH1) : 1;
    localparam int WW  = $clog2(N);

    // Circular scan of one class. Returns the class-local index of the first
    // requester at or after ptr. Class members sit at base..base+size-1 in r.
    function automatic int rr_pick(input logic [N-1:0] r, input int base,
                                   input int size, input int ptr);
        int best_d;
        int pick;
        int d;
        best_d = size;
        pick   = 0;
        for (int i = 0; i < N; i++) begin
            if (i >= base && i < base + size && r[i]) begin
                d = (i - base >= ptr) ? (i - base - ptr) : (i - base + size - ptr);
                if (d < best_d) begin
                    best_d = d;
                    pick   = i - base;
                end
            end
        end
        return pick;
    endfunction

    logic [P0W-1:0] rr0_reg, rr0_next;
    logic [P1W-1:0] rr1_reg, rr1_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [N-1:0]   resp_reg, resp_next;

    logic           any0, any1, live, starved, sel1, hs;
    logic [P0W-1:0] win0;
    logic [P1W-1:0] win1;
    logic [WW-1:0]  win_idx;
    logic [N-1:0]   gnt_vec;

    assign any0    = |bus.req[N_CH0-1:0];
    assign any1    = |bus.req[N-1:N_CH0];
    // While rst_ni is low the bank sees no request and nobody is granted.
    assign live    = (any0 | any1) & rst_ni;
    assign starved = (cnt_reg == CW'(MAX_STALL)) && any1;
    // Choose the low-priority class when it is starved or when it is the only one requesting.
    assign sel1    = starved || !any0;
    assign win0    = P0W'(rr_pick(bus.req, 0, N_CH0, int'(rr0_reg)));
    assign win1    = P1W'(rr_pick(bus.req, N_CH0, N_CH1, int'(rr1_reg)));
    assign win_idx = sel1 ? WW'(N_CH0 + int'(win1)) : WW'(win0);
    assign hs      = live && bus.mem_gnt;

    // Only the winner sees mem_gnt. Every other grant bit stays low.
    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
        assign gnt_vec[gi] = hs && (int'(win_idx) == gi);
    end

    assign bus.gnt     = gnt_vec;
    assign bus.mem_req = live;
    assign bus.starved = starved;
    assign bus.r_valid = resp_reg;
    assign bus.r_data  = bus.mem_r_data;

    // Route the winner's payload to the bank. The payload is zero when nobody requests.
    always_comb begin
        bus.mem_add  = '0;
        bus.mem_wen  = 1'b0;
        bus.mem_data = '0;
        bus.mem_be   = '0;
        if (live) begin
            bus.mem_add  = bus.add[int'(win_idx)*AW +: AW];
            bus.mem_wen  = bus.wen[win_idx];
            bus.mem_data = bus.data[int'(win_idx)*DW +: DW];
            bus.mem_be   = bus.be[int'(win_idx)*BW +: BW];
        end
    end

    // Next state: pointer advance on handshake, stall counting, response tag, clear.
    always_comb begin
        rr0_next  = rr0_reg;
        rr1_next  = rr1_reg;
        cnt_next  = cnt_reg;
        resp_next = '0;
        if (hs) begin
            resp_next[win_idx] = 1'b1;
            if (sel1) begin
                rr1_next = (int'(win1) == N_CH1 - 1) ? '0 : win1 + 1'b1;
            end else begin
                rr0_next = (int'(win0) == N_CH0 - 1) ? '0 : win0 + 1'b1;
            end
        end
        if ((hs && sel1) || !any1) begin
            cnt_next = '0;
        end else if (cnt_reg != CW'(MAX_STALL)) begin
            cnt_next = cnt_reg + 1'b1;
        end
        // clear_i wipes the state for the next cycle. Any pending response is dropped.
        if (clear_i) begin
            rr0_next  = '0;
            rr1_next  = '0;
            cnt_next  = '0;
            resp_next = '0;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr0_reg  <= '0;
            rr1_reg  <= '0;
            cnt_reg  <= '0;
            resp_reg <= '0;
        end else begin
            rr0_reg  <= rr0_next;
            rr1_reg  <= rr1_next;
            cnt_reg  <= cnt_next;
            resp_reg <= resp_next;
        end
    end
endmodule
